// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - sequencing FSM for the single-word-line memory datapath
//
// Purpose: stalls the CPU on misses and drives the datapath controls.
//   Loads:  a hit acks at once. A miss writes back a dirty victim,
//           allocates the line from memory, fills it, then re-checks.
//   Stores: always write through to memory. A store hit then refreshes
//           the line from memory. A store miss is write-around (no allocate).
//
// Ports:
//   clk           in   clock, all state updates on posedge
//   rst_b         in   synchronous active-low reset
//   cpu_req       in   CPU access request, held stable until ack
//   cpu_we        in   1 = store, 0 = load
//   hit           in   cache hit for the current address (combinational)
//   dirty_bit     in   indexed line is dirty
//   cache_we      out  write mem_data_out into the cache line
//   mem_in_select out  1 = victim address, 0 = CPU address
//   mem_we        out  memory write strobe
//   mem_re        out  memory read strobe
//   wr_data_sel   out  memory write data: 0 = cache data, 1 = CPU store data
//   ack           out  access completes this cycle (Mealy)
//   stall         out  cpu_req & ~ack
//   miss_cnt      out  saturating count of load and store misses
module cache_controller #(
  parameter int MEM_LATENCY = 4,
  parameter int CNT_W       = 3
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        hit,
  input  logic        dirty_bit,
  output logic        cache_we,
  output logic        mem_in_select,
  output logic        mem_we,
  output logic        mem_re,
  output logic        wr_data_sel,
  output logic        ack,
  output logic        stall,
  output logic [15:0] miss_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WB    = 3'd1,
    S_ALLOC = 3'd2,
    S_FILL  = 3'd3,
    S_STORE = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             st_done, st_done_nxt;
  logic             hit_q, hit_q_nxt;
  logic             miss_inc;
  logic [15:0]      miss_cnt_q;
  logic             lat_done;

  assign lat_done = (cnt == CNT_LAST);
  assign miss_cnt = miss_cnt_q;

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = '0;
    st_done_nxt   = st_done;
    hit_q_nxt     = hit_q;
    miss_inc      = 1'b0;
    cache_we      = 1'b0;
    mem_in_select = 1'b0;
    mem_we        = 1'b0;
    mem_re        = 1'b0;
    wr_data_sel   = 1'b0;
    ack           = 1'b0;

    case (state)
      S_IDLE: begin
        if (cpu_req) begin
          if (!cpu_we) begin
            if (hit) begin
              ack = 1'b1;
            end else begin
              miss_inc  = 1'b1;
              state_nxt = dirty_bit ? S_WB : S_ALLOC;
            end
          end else if (st_done) begin
            // Store chain already ran; this is the completion visit.
            ack         = 1'b1;
            st_done_nxt = 1'b0;
          end else begin
            hit_q_nxt = hit;
            miss_inc  = ~hit;
            state_nxt = S_STORE;
          end
        end else begin
          // An abandoned store must not ack a later, unrelated request.
          st_done_nxt = 1'b0;
        end
      end

      S_WB: begin
        mem_we        = 1'b1;
        mem_in_select = 1'b1;
        if (lat_done) state_nxt = S_ALLOC;
        else          cnt_nxt   = cnt + 1'b1;
      end

      S_ALLOC: begin
        mem_re = 1'b1;
        if (lat_done) state_nxt = S_FILL;
        else          cnt_nxt   = cnt + 1'b1;
      end

      S_FILL: begin
        cache_we  = 1'b1;
        state_nxt = S_IDLE;
      end

      S_STORE: begin
        mem_we      = 1'b1;
        wr_data_sel = 1'b1;
        if (lat_done) begin
          st_done_nxt = 1'b1;
          // A store hit leaves the cached copy stale; reload it.
          state_nxt   = hit_q ? S_ALLOC : S_IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      default: state_nxt = S_IDLE;
    endcase

    stall = cpu_req & ~ack;
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state      <= S_IDLE;
      cnt        <= '0;
      st_done    <= 1'b0;
      hit_q      <= 1'b0;
      miss_cnt_q <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      st_done <= st_done_nxt;
      hit_q   <= hit_q_nxt;
      if (miss_inc && (miss_cnt_q != 16'hFFFF)) miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - randomized bench for cache_controller against a phase-list model
module tb_cache_controller;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic        hit = 1'b0;
  logic        dirty_bit = 1'b0;
  logic        cache_we, mem_in_select, mem_we, mem_re, wr_data_sel, ack, stall;
  logic [15:0] miss_cnt;

  int          total = 0;
  int          bad = 0;
  logic [15:0] model_miss = 16'd0;
  // One entry per cycle: {cache_we, mem_in_select, mem_we, mem_re, wr_data_sel, ack}
  logic [5:0]  exp_q[$];

  localparam logic [5:0] V_NONE = 6'b000000;
  localparam logic [5:0] V_ACK  = 6'b000001;
  localparam logic [5:0] V_WB   = 6'b011000;
  localparam logic [5:0] V_RD   = 6'b000100;
  localparam logic [5:0] V_FILL = 6'b100000;
  localparam logic [5:0] V_ST   = 6'b001010;

  cache_controller #(.MEM_LATENCY(L), .CNT_W(3)) dut (
    .clk(clk), .rst_b(rst_b), .cpu_req(cpu_req), .cpu_we(cpu_we), .hit(hit),
    .dirty_bit(dirty_bit), .cache_we(cache_we), .mem_in_select(mem_in_select),
    .mem_we(mem_we), .mem_re(mem_re), .wr_data_sel(wr_data_sel), .ack(ack),
    .stall(stall), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] outs();
    return {cache_we, mem_in_select, mem_we, mem_re, wr_data_sel, ack};
  endfunction

  task automatic sample_cycle(input string tag, input logic [5:0] exp);
    logic [5:0] e;
    e = exp;
    if (!cpu_req) e[0] = 1'b0;
    #1;
    chk({tag, "_outs"}, 32'(outs()), 32'(e));
    chk({tag, "_stall"}, 32'(stall), 32'(cpu_req & ~e[0]));
    chk({tag, "_excl"}, 32'((cache_we & mem_we) | (mem_we & mem_re)), 32'd0);
  endtask

  // Expected per-cycle trace of one access, straight from the policy rules.
  task automatic build(input logic we, input logic h, input logic d);
    exp_q.delete();
    if (!we && h) begin
      exp_q.push_back(V_ACK);
      return;
    end
    exp_q.push_back(V_NONE);
    if (we) begin
      repeat (L) exp_q.push_back(V_ST);
      if (h) begin
        repeat (L) exp_q.push_back(V_RD);
        exp_q.push_back(V_FILL);
      end
    end else begin
      if (d) repeat (L) exp_q.push_back(V_WB);
      repeat (L) exp_q.push_back(V_RD);
      exp_q.push_back(V_FILL);
    end
    exp_q.push_back(V_ACK);
  endtask

  // drop_at < 0: request held throughout; otherwise cpu_req falls at that cycle.
  task automatic run_txn(input logic we, input logic h, input logic d, input int drop_at);
    int last;
    build(we, h, d);
    last = exp_q.size() - 1;
    if (!h && model_miss != 16'hFFFF) model_miss++;
    for (int i = 0; i <= last; i++) begin
      @(negedge clk);
      cpu_req   = (drop_at < 0) || (i < drop_at);
      cpu_we    = we;
      dirty_bit = d;
      // A load sees its line present once the fill has landed.
      hit       = we ? h : (h || (i == last));
      sample_cycle(we ? "st" : "ld", exp_q[i]);
    end
    chk("miss_cnt", 32'(miss_cnt), 32'(model_miss));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cpu_req   = 1'b0;
      cpu_we    = 1'($urandom_range(0, 1));
      hit       = 1'($urandom_range(0, 1));
      dirty_bit = 1'($urandom_range(0, 1));
      sample_cycle("idle", V_NONE);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_outs", 32'(outs()), 32'd0);
    chk("rst_miss", 32'(miss_cnt), 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    idle(2);

    // Directed: each access kind
    run_txn(1'b0, 1'b1, 1'b0, -1);
    run_txn(1'b0, 1'b0, 1'b0, -1);
    run_txn(1'b0, 1'b0, 1'b1, -1);
    run_txn(1'b1, 1'b1, 1'b0, -1);
    run_txn(1'b1, 1'b0, 1'b1, -1);
    idle(1);

    // Reset during the second WB cycle of a dirty load miss
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; hit = 1'b0; dirty_bit = 1'b1;
    sample_cycle("wbrst0", V_NONE);
    @(negedge clk);
    sample_cycle("wbrst1", V_WB);
    @(negedge clk);
    sample_cycle("wbrst2", V_WB);
    rst_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    cpu_req = 1'b0;
    sample_cycle("after_rst", V_NONE);
    chk("after_rst_miss", 32'(miss_cnt), 32'd0);
    model_miss = 16'd0;
    // Counter must restart from zero: a full dirty miss must still take 4+4 cycles.
    run_txn(1'b0, 1'b0, 1'b1, -1);

    // Request dropped while allocating: chain completes, no ack
    run_txn(1'b0, 1'b0, 1'b0, 2);
    idle(1);
    // Dropped store: the later load hit must ack normally, store state cleared
    run_txn(1'b1, 1'b0, 1'b0, 3);
    idle(1);
    run_txn(1'b0, 1'b1, 1'b0, -1);

    // Randomized accesses
    for (int t = 0; t < 40; t++) begin
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), -1);
      idle($urandom_range(0, 2));
    end

    // Saturation from a preloaded count
    @(negedge clk);
    cpu_req = 1'b0;
    force dut.miss_cnt_q = 16'hFFFE;
    #1;
    release dut.miss_cnt_q;
    model_miss = 16'hFFFE;
    chk("preload", 32'(miss_cnt), 32'h0000FFFE);
    run_txn(1'b1, 1'b0, 1'b0, -1);
    chk("sat1", 32'(miss_cnt), 32'h0000FFFF);
    run_txn(1'b0, 1'b0, 1'b0, -1);
    chk("sat2", 32'(miss_cnt), 32'h0000FFFF);
    run_txn(1'b0, 1'b0, 1'b1, -1);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
